// File: rtl/ofdm_ifft_serial.sv
// ofdm_ifft_serial
// Iterative radix-2 DIT inverse FFT with one butterfly per clock.
//
// Samples are loaded at bit-reversed addresses. The block then runs LOG2N
// in-place stages. Each stage halves its result, which gives an overall
// 1/NFFT scale. Results are streamed out in natural order.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_i/in_q are the signed input sample
//   out_valid/out_ready output handshake; out_i/out_q are the signed output sample
//   out_last            marks output index NFFT-1
//   busy                high while computing or unloading
module ofdm_ifft_serial #(
    parameter int NFFT  = 8,
    parameter int LOG2N = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_i,
    input  logic [15:0] in_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic        out_last,
    output logic        busy
);
    localparam int AW = LOG2N;
    localparam int BW = LOG2N - 1;

    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;      // load index / unload index
    logic [BW-1:0]   bfly_q, bfly_d;
    logic [2:0]      stage_q, stage_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic signed [15:0] mem_i_q [NFFT];
    logic signed [15:0] mem_q_q [NFFT];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // cos(pi*i/32) in Q1.15, i = 0..16
    function automatic logic signed [15:0] quarter(input logic [4:0] i);
        logic signed [15:0] c;
        case (i)
            5'd0:    c = 16'sd32767;
            5'd1:    c = 16'sd32610;
            5'd2:    c = 16'sd32138;
            5'd3:    c = 16'sd31357;
            5'd4:    c = 16'sd30274;
            5'd5:    c = 16'sd28899;
            5'd6:    c = 16'sd27245;
            5'd7:    c = 16'sd25330;
            5'd8:    c = 16'sd23170;
            5'd9:    c = 16'sd20788;
            5'd10:   c = 16'sd18205;
            5'd11:   c = 16'sd15447;
            5'd12:   c = 16'sd12540;
            5'd13:   c = 16'sd9512;
            5'd14:   c = 16'sd6393;
            5'd15:   c = 16'sd3212;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

    // The twiddle angle is 2*pi*k/64, with k = 0..31 (upper half-plane only).
    function automatic logic signed [15:0] tw_cos(input logic [4:0] k);
        if (k <= 5'd16) return quarter(k);
        return -quarter(5'(6'd32 - {1'b0, k}));
    endfunction

    function automatic logic signed [15:0] tw_sin(input logic [4:0] k);
        if (k <= 5'd16) return quarter(5'd16 - k);
        return quarter(k - 5'd16);
    endfunction

    // ---------------- butterfly datapath ----------------
    logic [AW-1:0]      bx, h, j, p, q;
    logic [10:0]        kx;
    logic [4:0]         tw_k;
    logic signed [15:0] a_i, a_q, b_i, b_q, wc, ws;
    logic signed [31:0] p_ic, p_qs, p_is, p_qc;
    logic signed [32:0] sr_i, sr_q;
    logic signed [17:0] t_i, t_q;
    logic signed [18:0] s0_i, s0_q, s1_i, s1_q;

    always_comb begin
        bx   = {1'b0, bfly_q};
        h    = AW'(1) << stage_q;
        j    = bx & (h - AW'(1));
        p    = ((bx >> stage_q) << (stage_q + 3'd1)) | j;
        q    = p + h;
        // m*(64/NFFT) = j << (5-s): index into the 64-point table
        kx   = 11'(j) << (3'd5 - stage_q);
        tw_k = kx[4:0];
        a_i  = mem_i_q[p];
        a_q  = mem_q_q[p];
        b_i  = mem_i_q[q];
        b_q  = mem_q_q[q];
        wc   = tw_cos(tw_k);
        ws   = tw_sin(tw_k);
        p_ic = b_i * wc;
        p_qs = b_q * ws;
        p_is = b_i * ws;
        p_qc = b_q * wc;
        sr_i = p_ic - p_qs;
        sr_q = p_is + p_qc;
        // m == 0 bypasses the multiplier so that the 32767 "one" cannot shrink data
        if (tw_k == 5'd0) begin
            t_i = {{2{b_i[15]}}, b_i};
            t_q = {{2{b_q[15]}}, b_q};
        end else begin
            t_i = sr_i[32:15];
            t_q = sr_q[32:15];
        end
        s0_i = a_i + t_i;
        s0_q = a_q + t_q;
        s1_i = a_i - t_i;
        s1_q = a_q - t_q;
    end

    logic unused_bits;
    assign unused_bits = ^{sr_i[14:0], sr_q[14:0], kx[10:5],
                           s0_i[18:17], s0_i[0], s0_q[18:17], s0_q[0],
                           s1_i[18:17], s1_i[0], s1_q[18:17], s1_q[0]};

    logic load_we, calc_we;
    assign load_we = (state_q == LOAD) && in_valid && in_ready_q;
    assign calc_we = (state_q == CALC);

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_i_q[bitrev(cnt_q)] <= in_i;
            mem_q_q[bitrev(cnt_q)] <= in_q;
        end
        if (calc_we) begin
            mem_i_q[p] <= s0_i[16:1];
            mem_q_q[p] <= s0_q[16:1];
            mem_i_q[q] <= s1_i[16:1];
            mem_q_q[q] <= s1_q[16:1];
        end
    end

    // ---------------- control ----------------
    // The handshake flags are registered from the current state. Each one
    // therefore rises one cycle after its state is entered and drops on the
    // edge that leaves it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bfly_d      = bfly_q;
        stage_d     = stage_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready_d = 1'b1;
                if (load_we) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(NFFT - 1)) begin
                        state_d    = CALC;
                        in_ready_d = 1'b0;
                    end
                end
            end
            CALC: begin
                bfly_d = bfly_q + BW'(1);
                if (bfly_q == {BW{1'b1}}) begin
                    stage_d = stage_q + 3'd1;
                    if (stage_q == 3'(LOG2N - 1)) begin
                        stage_d = 3'd0;
                        state_d = UNLOAD;
                    end
                end
            end
            UNLOAD: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(NFFT - 1)) begin
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            bfly_q      <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bfly_q      <= bfly_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (cnt_q == AW'(NFFT - 1));
    assign out_i     = out_valid_q ? mem_i_q[cnt_q] : 16'd0;
    assign out_q     = out_valid_q ? mem_q_q[cnt_q] : 16'd0;
    assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_ofdm_ifft_serial.sv
// Self-checking bench for ofdm_ifft_serial (NFFT=8).
// Directed frames (impulse, DC, tone) and random frames, checked against an
// arithmetic Cooley-Tukey reference. Also covers backpressure, reset during
// computation, and back-to-back frames with in_valid held high.
module tb_ofdm_ifft_serial;
    localparam int N = 8;
    localparam int L = 3;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [15:0] in_i, in_q, out_i, out_q;

    int ncmp = 0;
    int nfail = 0;
    int xi[N], xq[N], yi[N], yq[N], ei[N], eq[N], x2i[N], x2q[N];

    ofdm_ifft_serial #(.NFFT(N), .LOG2N(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input real exp, input int tol);
        real d;
        d = real'(obs) - exp;
        ncmp++;
        assert (d <= real'(tol) && d >= -real'(tol)) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0.2f(+-%0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < L; b++) if (k & (1 << b)) r |= 1 << (L - 1 - b);
        return r;
    endfunction

    function automatic int q15(input real x);
        int v = int'(x * 32768.0);
        return (v > 32767) ? 32767 : v;
    endfunction

    function automatic int w16(input int v);
        return int'(shortint'(v));
    endfunction

    // Reference: textbook iterative radix-2 IFFT with per-stage halving.
    function automatic void model(input int ii[N], input int iq[N],
                                  output int oi[N], output int oq[N]);
        int ar[N], aq[N];
        int h, m, pp, qq, wc, ws, tr, ti, ur, uq;
        real ang;
        for (int k = 0; k < N; k++) begin
            ar[rev(k)] = ii[k];
            aq[rev(k)] = iq[k];
        end
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            for (int base = 0; base < N; base += 2 * h) begin
                for (int jj = 0; jj < h; jj++) begin
                    m  = jj * (N / (2 * h));
                    pp = base + jj;
                    qq = pp + h;
                    if (m == 0) begin
                        tr = ar[qq];
                        ti = aq[qq];
                    end else begin
                        ang = 2.0 * PI * real'(m) / real'(N);
                        wc  = q15($cos(ang));
                        ws  = q15($sin(ang));
                        tr  = int'((longint'(ar[qq]) * wc - longint'(aq[qq]) * ws) >>> 15);
                        ti  = int'((longint'(ar[qq]) * ws + longint'(aq[qq]) * wc) >>> 15);
                    end
                    ur = ar[pp];
                    uq = aq[pp];
                    ar[pp] = w16((ur + tr) >>> 1);
                    aq[pp] = w16((uq + ti) >>> 1);
                    ar[qq] = w16((ur - tr) >>> 1);
                    aq[qq] = w16((uq - ti) >>> 1);
                end
            end
        end
        oi = ar;
        oq = aq;
    endfunction

    // Load one frame. When 'hold' is set, in_valid stays high afterwards,
    // presenting (hi, hq).
    task automatic send(input int si[N], input int sq[N], input bit hold,
                        input int hi, input int hq);
        int g;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_i = 16'(si[k]);
            in_q = 16'(sq[k]);
            g = 0;
            while (!in_ready && g < 100) begin
                tick();
                g++;
            end
            chk("in_ready_beat", int'(in_ready), 1);
            tick();
        end
        in_valid = hold;
        in_i = hold ? 16'(hi) : 16'd0;
        in_q = hold ? 16'(hq) : 16'd0;
    endtask

    // Receive one frame, optionally with random out_ready.
    task automatic recv(input bit rnd, input bit chk_lat, output int ri[N], output int rq[N]);
        int n, lat, g, pi, pq;
        bit rdy;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (chk_lat) chk("latency", lat, 13);
        n = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            ri[k] = 0;
            rq[k] = 0;
        end
        while (n < N && g < 400) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            chk("out_valid_hold", int'(out_valid), 1);
            chk("in_ready_unload", int'(in_ready), 0);
            chk("out_last", int'(out_last), int'(n == N - 1));
            pi = int'($signed(out_i));
            pq = int'($signed(out_q));
            tick();
            g++;
            if (rdy) begin
                ri[n] = pi;
                rq[n] = pq;
                n++;
            end else begin
                chk("stall_i", int'($signed(out_i)), pi);
                chk("stall_q", int'($signed(out_q)), pq);
            end
        end
        out_ready = 1'b0;
        chk("frame_beats", n, N);
        chk("in_ready_after_U", int'(in_ready), 0);
        chk("busy_after_U", int'(busy), 0);
        chk("out_valid_after_U", int'(out_valid), 0);
        tick();
        chk("in_ready_after_U1", int'(in_ready), 1);
    endtask

    task automatic clear_x();
        for (int k = 0; k < N; k++) begin
            xi[k] = 0;
            xq[k] = 0;
        end
    endtask

    task automatic rand_x();
        for (int k = 0; k < N; k++) begin
            xi[k] = int'($urandom_range(0, 32000)) - 16000;
            xq[k] = int'($urandom_range(0, 32000)) - 16000;
        end
    endtask

    task automatic chk_model(input string tag);
        model(xi, xq, ei, eq);
        for (int k = 0; k < N; k++) begin
            chk({tag, "_i"}, yi[k], ei[k]);
            chk({tag, "_q"}, yq[k], eq[k]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_i", int'(out_i), 0);
        rst_n = 1'b1;
        chk("rel_in_ready_pre", int'(in_ready), 0);
        tick();
        chk("rel_in_ready", int'(in_ready), 1);

        // Impulse
        clear_x();
        xi[0] = 16384;
        send(xi, xq, 1'b0, 0, 0);
        chk("calc_busy", int'(busy), 1);
        chk("calc_in_ready", int'(in_ready), 0);
        recv(1'b0, 1'b1, yi, yq);
        for (int k = 0; k < N; k++) begin
            chk("imp_i", yi[k], 2048);
            chk("imp_q", yq[k], 0);
        end

        // DC bin
        clear_x();
        xi[0] = 8192;
        send(xi, xq, 1'b0, 0, 0);
        recv(1'b0, 1'b1, yi, yq);
        for (int k = 0; k < N; k++) begin
            chk("dc_i", yi[k], 1024);
            chk("dc_q", yq[k], 0);
        end

        // Tone in bin 1
        clear_x();
        xi[1] = 16384;
        send(xi, xq, 1'b0, 0, 0);
        recv(1'b0, 1'b1, yi, yq);
        chk("tone0_i", yi[0], 2048);
        chk("tone0_q", yq[0], 0);
        for (int k = 0; k < N; k++) begin
            chk_near("tone_i", yi[k], 2048.0 * $cos(2.0 * PI * k / N), 2);
            chk_near("tone_q", yq[k], 2048.0 * $sin(2.0 * PI * k / N), 2);
        end
        chk_model("tone");

        // Random frames with random backpressure
        for (int f = 0; f < 4; f++) begin
            rand_x();
            send(xi, xq, 1'b0, 0, 0);
            recv(1'b1, 1'b1, yi, yq);
            chk_model("rand");
        end

        // Reset in the middle of computation
        rand_x();
        send(xi, xq, 1'b0, 0, 0);
        repeat (4) tick();
        chk("midcalc_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_last", int'(out_last), 0);
        chk("arst_out_q", int'(out_q), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_in_ready", int'(in_ready), 1);
        clear_x();
        xi[0] = 16384;
        send(xi, xq, 1'b0, 0, 0);
        recv(1'b0, 1'b1, yi, yq);
        for (int k = 0; k < N; k++) begin
            chk("post_rst_i", yi[k], 2048);
            chk("post_rst_q", yq[k], 0);
        end

        // Back-to-back frames with in_valid held high
        for (int k = 0; k < N; k++) begin
            x2i[k] = int'($urandom_range(0, 32000)) - 16000;
            x2q[k] = int'($urandom_range(0, 32000)) - 16000;
        end
        rand_x();
        send(xi, xq, 1'b1, x2i[0], x2q[0]);
        recv(1'b1, 1'b1, yi, yq);
        chk_model("b2b1");
        xi = x2i;
        xq = x2q;
        send(xi, xq, 1'b0, 0, 0);
        recv(1'b0, 1'b1, yi, yq);
        chk_model("b2b2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
